// File: rtl/sdram_cmd_responder_if.sv
// rtl/sdram_cmd_responder_if.sv - command/response FIFO bundle between a command source and the responder
//
// Purpose: groups the show-ahead command FIFO head, its pop strobe, the single-read and
// burst-read response FIFO pushes and the responder status flags into one bundle.
// Ports (bundle members):
//    cmd_d_i      [59:0]  command FIFO head: [59:40] op, [39:16] word address, [15:0] write data
//    cmd_empty_i          command FIFO empty
//    cmd_deq_o            one-cycle pop of the command FIFO
//    rsp_q_o      [15:0]  single-read data
//    rsp_enq_o            one-cycle push into the response FIFO
//    rsp_full_i           response FIFO full
//    burst_q_o    [127:0] burst-read data, word k in [16k+15:16k]
//    burst_enq_o          one-cycle push into the burst FIFO
//    burst_full_i         burst FIFO full
//    busy_o               responder is working on a command
//    err_o                sticky unknown-op flag
// Modports: master = command source / FIFO side, slave = responder.

interface sdram_cmd_responder_if;
   logic [59:0]  cmd_d_i;
   logic         cmd_empty_i;
   logic         cmd_deq_o;
   logic [15:0]  rsp_q_o;
   logic         rsp_enq_o;
   logic         rsp_full_i;
   logic [127:0] burst_q_o;
   logic         burst_enq_o;
   logic         burst_full_i;
   logic         busy_o;
   logic         err_o;

   modport master (
      output cmd_d_i, cmd_empty_i, rsp_full_i, burst_full_i,
      input  cmd_deq_o, rsp_q_o, rsp_enq_o, burst_q_o, burst_enq_o, busy_o, err_o
   );

   modport slave (
      input  cmd_d_i, cmd_empty_i, rsp_full_i, burst_full_i,
      output cmd_deq_o, rsp_q_o, rsp_enq_o, burst_q_o, burst_enq_o, busy_o, err_o
   );
endinterface

// File: rtl/sdram_cmd_responder.sv
// rtl/sdram_cmd_responder.sv - cycle-accurate SDRAM controller stand-in behind command/response FIFOs
//
// Purpose: pops commands from the command FIFO one at a time and runs them against an internal
// 2^ADDR_WIDTH x 16-bit memory. Single reads push one word into the response FIFO, and burst
// reads push BURST_LEN words into the burst FIFO. Unknown ops set a sticky error flag.
// Ports:
//    clk       single clock
//    reset_ni  asynchronous active-low reset (memory contents are not cleared)
//    bus       sdram_cmd_responder_if.slave, the command/response FIFO bundle
// Parameters:
//    ADDR_WIDTH  word-address bits of the internal memory; higher address bits alias
//    BURST_LEN   words per burst read (BURST_LEN*16 must equal 128)

module sdram_cmd_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int BURST_LEN  = 8
) (
   input  logic                    clk,
   input  logic                    reset_ni,
   sdram_cmd_responder_if.slave    bus
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   localparam logic [19:0] OP_READ  = 20'd0;
   localparam logic [19:0] OP_WRITE = 20'd1;
   localparam logic [19:0] OP_BURST = 20'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_RD_WAIT,
      S_RSP,
      S_BURST,
      S_BURST_RSP
   } state_e;

   state_e                    state_q, state_d;
   logic [19:0]               op_q, op_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [15:0]               wdata_q, wdata_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [15:0]               rsp_data_q, rsp_data_d;
   logic [BURST_LEN*16-1:0]   burst_data_q, burst_data_d;
   logic                      err_q, err_d;

   logic                      cmd_deq;
   logic                      rsp_enq;
   logic                      burst_enq;
   logic                      mem_we;
   logic [ADDR_WIDTH-1:0]     mem_addr;
   logic [15:0]               mem_rdata_q;
   logic [15:0]               mem [0:(1 << ADDR_WIDTH) - 1];

   // Address bits above the memory size are ignored, so addresses alias.
   if (ADDR_WIDTH < 24) begin : g_alias
      logic unused_addr_bits;
      assign unused_addr_bits = ^bus.cmd_d_i[39:16+ADDR_WIDTH];
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rsp_data_d   = rsp_data_q;
      burst_data_d = burst_data_q;
      err_d        = err_q;
      cmd_deq      = 1'b0;
      rsp_enq      = 1'b0;
      burst_enq    = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = addr_q;

      case (state_q)
         S_IDLE: begin
            if (!bus.cmd_empty_i) begin
               cmd_deq = 1'b1;
               op_d    = bus.cmd_d_i[59:40];
               addr_d  = bus.cmd_d_i[16 +: ADDR_WIDTH];
               wdata_d = bus.cmd_d_i[15:0];
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            // mem_addr already points at addr_q, which is the read / first burst address.
            case (op_q)
               OP_WRITE: begin
                  mem_we  = 1'b1;
                  state_d = S_IDLE;
               end
               OP_READ: begin
                  state_d = S_RD_WAIT;
               end
               OP_BURST: begin
                  cnt_d   = '0;
                  state_d = S_BURST;
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            endcase
         end
         S_RD_WAIT: begin
            rsp_data_d = mem_rdata_q;
            state_d    = S_RSP;
         end
         S_RSP: begin
            if (!bus.rsp_full_i) begin
               rsp_enq = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_BURST: begin
            // The word returning now belongs to slot cnt_q; run the address one ahead of it.
            // The final extra read past the burst is harmless.
            mem_addr = addr_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
            for (int k = 0; k < BURST_LEN; k++) begin
               if (cnt_q == CNT_W'(k)) begin
                  burst_data_d[k*16 +: 16] = mem_rdata_q;
               end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_BURST_RSP;
            end
         end
         S_BURST_RSP: begin
            if (!bus.burst_full_i) begin
               burst_enq = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         rsp_data_q   <= '0;
         burst_data_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rsp_data_q   <= rsp_data_d;
         burst_data_q <= burst_data_d;
         err_q        <= err_d;
      end
   end

   // Word memory with a registered read port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr_q] <= wdata_q;
      end
      mem_rdata_q <= mem[mem_addr];
   end

   // The pop is decoded from IDLE, which is also the reset state, so it is masked by reset
   // to keep every output low while reset is held.
   assign bus.cmd_deq_o   = cmd_deq & reset_ni;
   assign bus.rsp_enq_o   = rsp_enq;
   assign bus.burst_enq_o = burst_enq;
   assign bus.rsp_q_o     = rsp_data_q;
   assign bus.burst_q_o   = burst_data_q;
   assign bus.busy_o      = (state_q != S_IDLE);
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// tb/tb_sdram_cmd_responder.sv - self-checking bench for sdram_cmd_responder
module tb_sdram_cmd_responder;

   logic clk = 1'b0;
   logic reset_ni;
   always #5 clk = ~clk;

   sdram_cmd_responder_if bus ();

   sdram_cmd_responder #(.ADDR_WIDTH(10), .BURST_LEN(8)) dut (
      .clk      (clk),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0]  mem_m [1024];
   bit           pend_v     = 0;
   bit           pend_burst = 0;
   logic [127:0] pend_data;
   int           pend_due;
   int           pend_deq;
   int           last_deq   = -100;
   int           err_cycle  = -1;
   logic [15:0]  last_rsp   = '0;
   logic [127:0] last_burst = '0;
   int           rsp_cnt = 0, burst_cnt = 0, deq_cnt = 0;
   logic [15:0]  rsp_log[$];
   logic [127:0] burst_log[$];
   int           rsp_lat[$];
   int           burst_lat[$];

   always @(negedge clk) begin
      bit           exp_busy, exp_deq, exp_err, exp_renq, exp_benq, chk_bq;
      logic [15:0]  exp_rq;
      logic [127:0] exp_bq;
      logic [19:0]  op;
      int           idx;
      cyc++;
      if (!reset_ni) begin
         chk("rst_deq",  bus.cmd_deq_o,   0);
         chk("rst_renq", bus.rsp_enq_o,   0);
         chk("rst_benq", bus.burst_enq_o, 0);
         chk("rst_busy", bus.busy_o,      0);
         chk("rst_err",  bus.err_o,       0);
         chk("rst_rq",   bus.rsp_q_o,     0);
         chk("rst_bq",   bus.burst_q_o,   0);
         pend_v = 0; last_deq = -100; err_cycle = -1; last_rsp = '0; last_burst = '0;
      end else begin
         exp_busy = (cyc == last_deq + 1) || (pend_v && cyc > last_deq);
         exp_deq  = !bus.cmd_empty_i && !exp_busy;
         exp_err  = (err_cycle >= 0) && (cyc >= err_cycle + 2);
         exp_renq = 0; exp_benq = 0; chk_bq = 1;
         exp_rq   = last_rsp; exp_bq = last_burst;
         if (pend_v && !pend_burst && cyc >= pend_due) begin
            exp_rq   = pend_data[15:0];
            exp_renq = !bus.rsp_full_i;
         end
         if (pend_v && pend_burst) begin
            if (cyc >= pend_due) begin
               exp_bq   = pend_data;
               exp_benq = !bus.burst_full_i;
            end else begin
               chk_bq = 0;
            end
         end
         chk("busy", bus.busy_o,      exp_busy);
         chk("deq",  bus.cmd_deq_o,   exp_deq);
         chk("err",  bus.err_o,       exp_err);
         chk("renq", bus.rsp_enq_o,   exp_renq);
         chk("benq", bus.burst_enq_o, exp_benq);
         chk("rq",   bus.rsp_q_o,     exp_rq);
         if (chk_bq) chk("bq", bus.burst_q_o, exp_bq);

         if (bus.rsp_enq_o) begin
            rsp_cnt++; rsp_log.push_back(bus.rsp_q_o); rsp_lat.push_back(cyc - pend_deq);
         end
         if (bus.burst_enq_o) begin
            burst_cnt++; burst_log.push_back(bus.burst_q_o); burst_lat.push_back(cyc - pend_deq);
         end
         if (exp_renq) begin last_rsp = pend_data[15:0]; pend_v = 0; end
         if (exp_benq) begin last_burst = pend_data; pend_v = 0; end

         if (bus.cmd_deq_o) begin
            deq_cnt++;
            last_deq = cyc;
            op  = bus.cmd_d_i[59:40];
            idx = int'(bus.cmd_d_i[39:16]) % 1024;
            if (op == 20'd1) begin
               mem_m[idx] = bus.cmd_d_i[15:0];
            end else if (op == 20'd0) begin
               pend_v = 1; pend_burst = 0; pend_deq = cyc; pend_due = cyc + 3;
               pend_data = {112'd0, mem_m[idx]};
            end else if (op == 20'd2) begin
               pend_v = 1; pend_burst = 1; pend_deq = cyc; pend_due = cyc + 8 + 2;
               for (int k = 0; k < 8; k++) pend_data[16*k +: 16] = mem_m[(idx + k) % 1024];
            end else if (err_cycle < 0) begin
               err_cycle = cyc;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_deq();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cmd_deq_o && n < 60);
      if (!bus.cmd_deq_o) begin
         checks++; failures++;
         $display("FAIL wait_deq timeout actual=no_pop expected=pop");
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy_o && n < 100);
      if (bus.busy_o) begin
         checks++; failures++;
         $display("FAIL wait_idle timeout actual=busy expected=idle");
      end
   endtask

   task automatic send(input logic [59:0] c);
      @(posedge clk); #1;
      bus.cmd_d_i = c; bus.cmd_empty_i = 1'b0;
      wait_deq();
      @(posedge clk); #1;
      bus.cmd_empty_i = 1'b1;
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r0, b0, d0;
      logic [127:0] bl;
      reset_ni = 1'b0;
      bus.cmd_d_i = '0; bus.cmd_empty_i = 1'b1;
      bus.rsp_full_i = 1'b0; bus.burst_full_i = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("init_busy", bus.busy_o, 0);
      chk("init_rq",   bus.rsp_q_o, 0);
      reset_ni = 1'b1;

      // write then read back
      send({20'd1, 24'h1000, 16'h1000});
      send({20'd0, 24'h1000, 16'h0000});
      chk("t1_data", rsp_log[$], 16'h1000);
      chk("t1_lat",  rsp_lat[$], 3);
      chk("t1_err",  bus.err_o, 0);

      // burst of eight consecutive words
      for (int k = 0; k < 8; k++) send({20'd1, 24'(32'h2000 + k), 16'(16'h00A0 + k)});
      b0 = burst_cnt;
      send({20'd2, 24'h2000, 16'h0});
      chk("t2_data", burst_log[$], 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
      chk("t2_cnt",  burst_cnt, b0 + 1);
      chk("t2_lat",  burst_lat[$], 10);

      // response FIFO back-pressure with a second command waiting
      send({20'd1, 24'h1000, 16'h1000});
      @(posedge clk); #1;
      r0 = rsp_cnt;
      bus.rsp_full_i = 1'b1;
      bus.cmd_d_i = {20'd0, 24'h1000, 16'h0}; bus.cmd_empty_i = 1'b0;
      wait_deq();
      @(posedge clk); #1;
      bus.cmd_d_i = {20'd0, 24'h2003, 16'h0};
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("t3_busy", bus.busy_o, 1);
      chk("t3_held", rsp_cnt, r0);
      chk("t3_rq",   bus.rsp_q_o, 16'h1000);
      @(posedge clk); #1;
      bus.rsp_full_i = 1'b0;
      wait_deq();
      @(posedge clk); #1;
      bus.cmd_empty_i = 1'b1;
      wait_idle();
      chk("t3_cnt",    rsp_cnt, r0 + 2);
      chk("t3_first",  rsp_log[rsp_log.size() - 2], 16'h1000);
      chk("t3_second", rsp_log[$], 16'h00A3);

      // burst wrap at the top of memory, then address aliasing
      send({20'd1, 24'h0003FF, 16'hBEEF});
      send({20'd1, 24'h000000, 16'h1234});
      send({20'd2, 24'h0003FF, 16'h0});
      bl = burst_log[$];
      chk("t4_w0", bl[15:0],  16'hBEEF);
      chk("t4_w1", bl[31:16], 16'h1234);
      send({20'd1, 24'h000400, 16'h5555});
      send({20'd0, 24'h000000, 16'h0});
      chk("t4_alias", rsp_log[$], 16'h5555);

      // unknown op
      d0 = deq_cnt; r0 = rsp_cnt; b0 = burst_cnt;
      send({20'd7, 24'h000005, 16'hFFFF});
      chk("t5_err",   bus.err_o, 1);
      chk("t5_deq",   deq_cnt, d0 + 1);
      chk("t5_rsp",   rsp_cnt, r0);
      chk("t5_burst", burst_cnt, b0);
      send({20'd0, 24'h0003FF, 16'h0});
      chk("t5_read",  rsp_log[$], 16'hBEEF);
      chk("t5_err2",  bus.err_o, 1);

      // reset in the middle of a burst
      @(posedge clk); #1;
      bus.cmd_d_i = {20'd2, 24'h2000, 16'h0}; bus.cmd_empty_i = 1'b0;
      wait_deq();
      @(posedge clk); #1;
      bus.cmd_empty_i = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("t6_busy_pre", bus.busy_o, 1);
      reset_ni = 1'b0;
      #1;
      chk("t6_busy", bus.busy_o,    0);
      chk("t6_err",  bus.err_o,     0);
      chk("t6_rq",   bus.rsp_q_o,   0);
      chk("t6_bq",   bus.burst_q_o, 0);
      chk("t6_benq", bus.burst_enq_o, 0);
      @(negedge clk);
      @(posedge clk); #1;
      reset_ni = 1'b1;
      b0 = burst_cnt;
      repeat (20) @(posedge clk); #1;
      chk("t6_no_burst", burst_cnt, b0);
      chk("t6_idle", bus.busy_o, 0);
      send({20'd1, 24'h000010, 16'h7777});
      send({20'd0, 24'h000010, 16'h0});
      chk("t6_read", rsp_log[$], 16'h7777);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_cmd_responder.md
Name: sdram_cmd_responder

Overview:
- Responder end of the async SDRAM controller's command/response FIFO protocol. It pops 60-bit commands from a command FIFO, executes them against an internal word memory, and pushes 16-bit single-read and 128-bit burst-read results into response FIFOs.
- Used as a cycle-accurate stand-in for async_sdram_ctrl behind the same FIFOs. This lets command generators and checkers run without the SDRAM device.

Parameters:
- ADDR_WIDTH, 10, word-address bits of the internal memory (2^ADDR_WIDTH x 16-bit words).
- BURST_LEN, 8, words per burst read; fixed so that BURST_LEN*16 = 128.

Ports:
- clk  in  1  single clock.
- reset_ni  in  1  asynchronous active-low reset.
- cmd_d_i  in  60  show-ahead head of command FIFO; valid while cmd_empty_i=0. Fields: [59:40] op, [39:16] word address, [15:0] write data.
- cmd_empty_i  in  1  command FIFO empty.
- cmd_deq_o  out  1  one-cycle pop of the command FIFO.
- rsp_q_o  out  16  single-read data.
- rsp_enq_o  out  1  one-cycle push into the response FIFO.
- rsp_full_i  in  1  response FIFO full.
- burst_q_o  out  128  burst-read data; word k sits in [16k+15:16k].
- burst_enq_o  out  1  one-cycle push into the burst FIFO.
- burst_full_i  in  1  burst FIFO full.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky flag: an unknown op was received.

Behaviour:
- Reset: asserting reset_ni=0 clears every output to 0 asynchronously and puts the FSM in IDLE. Memory contents are not reset and are undefined until written. Reset in the middle of a command abandons it; the command is not re-executed after reset.
- Op decode on cmd_d_i[59:40]:
  - 20'd0 = single read.
  - 20'd1 = single write.
  - 20'd2 = burst read.
  - Any other value = unknown.
- Addressing: the memory index is cmd_d_i[16+ADDR_WIDTH-1:16]. Higher address bits are ignored, so addresses alias.
- Burst addressing: word k uses (addr+k) mod 2^ADDR_WIDTH, i.e. the burst wraps at the top of memory.
- Memory read is registered: data appears one cycle after the address is presented.
- FSM states: IDLE, EXEC, RD_WAIT, RSP, BURST, BURST_RSP.
- IDLE:
  - If cmd_empty_i=0: latch cmd_d_i, pulse cmd_deq_o for exactly one cycle, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - Write: write data to memory this cycle, go to IDLE.
  - Read: present the address, go to RD_WAIT.
  - Burst: present addr+0, clear the word counter, go to BURST.
  - Unknown: set err_o, go to IDLE. The command is discarded with no memory or FIFO effect.
- RD_WAIT: capture memory data into rsp_q_o, go to RSP.
- RSP:
  - If rsp_full_i=0: pulse rsp_enq_o for one cycle, go to IDLE.
  - Otherwise hold in RSP with rsp_q_o stable and rsp_enq_o=0.
- BURST:
  - Each cycle present the next address and place the returning word into slot k of burst_q_o.
  - After BURST_LEN words have been captured, go to BURST_RSP.
- BURST_RSP:
  - If burst_full_i=0: pulse burst_enq_o, go to IDLE.
  - Otherwise hold with burst_q_o stable.
- Ordering: strictly one command at a time. A read issued after a write to the same address returns the written value.
- Latency, with cmd_deq_o at cycle 0 and the response FIFOs not full:
  - Write completes in memory at cycle 1; the next cmd_deq_o is possible at cycle 2.
  - rsp_enq_o at cycle 3.
  - burst_enq_o at cycle BURST_LEN+2.
- Never more than one enq per command. cmd_deq_o is never asserted while cmd_empty_i=1 or while busy_o=1.
- rsp_q_o and burst_q_o keep their last values between responses.

Test Plan:
- Write {20'd1,24'h1000,16'h1000}, then read {20'd0,24'h1000,16'h0}.
  - Expect one rsp_enq_o with rsp_q_o=16'h1000, 3 cycles after the read's cmd_deq_o.
  - Expect err_o=0.
- Write 16'hA0+k to addresses 24'h2000+k for k=0..7, then issue {20'd2,24'h2000,16'h0}.
  - Expect burst_q_o=128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0 and exactly one burst_enq_o.
- Hold rsp_full_i=1 for 10 cycles during a read of 16'h1000.
  - Expect rsp_enq_o=0 and rsp_q_o stable throughout, busy_o=1, no cmd_deq_o.
  - After release: one rsp_enq_o, then return to IDLE.
- With ADDR_WIDTH=10, write 16'hBEEF at 24'h3FF and 16'h1234 at 24'h000, then burst-read from 24'h3FF.
  - Expect word0=16'hBEEF, word1=16'h1234 (burst wrap).
  - Write 16'h5555 at 24'h400, then read 24'h000: expect 16'h5555 (aliasing).
- Send op 20'd7.
  - Expect err_o=1 (sticky), one cmd_deq_o, no enq on either response FIFO.
  - A following read still returns correct data.
- Drive reset_ni=0 while in the BURST state.
  - All outputs go to 0 immediately and the FSM returns to IDLE.
  - After release, no burst_enq_o is produced until a new command arrives.
